// File: rtl/conv_bridge_pkg.sv
// conv_bridge_pkg: bridge state encoding and default sizing shared by the
// HPS-to-convolution bridge, its interface and its bench.
package conv_bridge_pkg;

  localparam int DEF_DATA_W      = 25;
  localparam int DEF_RES_W       = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/conv_hps_bridge_if.sv
// conv_hps_bridge_if: operand/result handshake between the bridge (master)
// and the convolution core (slave).
interface conv_hps_bridge_if
  import conv_bridge_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RES_W  = DEF_RES_W
);

  logic              valid;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] k;
  logic              conv_ready;
  logic              res_valid;
  logic [RES_W-1:0]  res;
  logic              res_ready;

  modport master (
    output valid, x, k, res_ready,
    input  conv_ready, res_valid, res
  );

  modport slave (
    input  valid, x, k, res_ready,
    output conv_ready, res_valid, res
  );

endinterface

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones. q_next is the
// value the counter takes at this edge, so a same-cycle capture includes it.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q_next
);

  logic [W-1:0] q;

  // NOTE: default assigned first so every path drives q_next; no latch.
  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = '0;
    end else if (en && (q != '1)) begin
      q_next = q + 1'b1;
    end
  end

  // NOTE: non-blocking for registered state so evaluation order is irrelevant.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/conv_hps_bridge.sv
// conv_hps_bridge: turns HPS toggle-bit requests into one valid/ready operand
// transfer and returns result, job count and latency. Watchdog: CONV_BRIDGE_TIMEOUT_EN.
module conv_hps_bridge
  import conv_bridge_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RES_W  = DEF_RES_W,
  parameter int CNT_W  = DEF_CNT_W
`ifdef CONV_BRIDGE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_tog,
  input  logic                     i_ack_tog,
  input  logic [DATA_W-1:0]        i_x,
  input  logic [DATA_W-1:0]        i_k,
  conv_hps_bridge_if.master        conv,
  output logic [RES_W-1:0]         o_res,
  output logic                     o_busy,
  output logic                     o_done_tog,
  output logic                     o_err_overrun,
  output logic                     o_err_timeout,
  output logic [CNT_W-1:0]         o_job_cnt,
  output logic [CNT_W-1:0]         o_lat_cycles
);

  state_e           state, state_nxt;
  logic             req_q;
  logic             req_edge, start, counting, xfer, capture, ack, timeout;
  logic [CNT_W-1:0] lat_next;

  assign req_edge = i_req_tog ^ req_q;
  assign start    = (state == IDLE) && req_edge;
  assign counting = (state == SEND) || (state == WAIT);
  assign xfer     = (state == SEND) && conv.valid && conv.conv_ready;
  assign capture  = (state == WAIT) && conv.res_valid;
  assign ack      = (i_ack_tog == o_done_tog);

  sat_counter #(.W(CNT_W)) u_lat (
    .clk    (i_clk),
    .rst    (i_rst),
    .clr    (start),
    .en     (counting),
    .q_next (lat_next)
  );

`ifdef CONV_BRIDGE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_next;

  sat_counter #(.W(WD_W)) u_wd (
    .clk    (i_clk),
    .rst    (i_rst),
    .clr    (start),
    .en     (counting),
    .q_next (wd_next)
  );

  // A result arriving on the final watchdog cycle still counts as a real completion.
  assign timeout = counting && !capture && (wd_next == WD_W'(TIMEOUT_CYC));
`else
  assign timeout       = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    o_busy         = (state != IDLE);
    conv.res_ready = (state == WAIT);
    unique case (state)
      IDLE: if (start)   state_nxt = SEND;
      SEND: if (timeout) state_nxt = DONE;
            else if (xfer) state_nxt = WAIT;
      WAIT: if (capture || timeout) state_nxt = DONE;
      DONE: if (ack)     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // Adopt the current toggle level so reset release is not seen as a request.
      req_q         <= i_req_tog;
      conv.valid    <= 1'b0;
      conv.x        <= '0;
      conv.k        <= '0;
      o_res         <= '0;
      o_done_tog    <= 1'b0;
      o_err_overrun <= 1'b0;
      o_job_cnt     <= '0;
      o_lat_cycles  <= '0;
`ifdef CONV_BRIDGE_TIMEOUT_EN
      o_err_timeout <= 1'b0;
`endif
    end else begin
      req_q <= i_req_tog;
      if (start) begin
        conv.x     <= i_x;
        conv.k     <= i_k;
        conv.valid <= 1'b1;
      end
      if (xfer) begin
        conv.valid <= 1'b0;
      end
      if (req_edge && (state != IDLE)) begin
        o_err_overrun <= 1'b1;
      end
      if (capture) begin
        o_res        <= conv.res;
        o_job_cnt    <= o_job_cnt + 1'b1;
        o_lat_cycles <= lat_next;
        o_done_tog   <= ~o_done_tog;
      end
`ifdef CONV_BRIDGE_TIMEOUT_EN
      if (timeout) begin
        conv.valid    <= 1'b0;
        o_res         <= '0;
        o_lat_cycles  <= '1;
        o_done_tog    <= ~o_done_tog;
        o_err_timeout <= 1'b1;
      end
`endif
    end
  end

endmodule
